// File: rtl/tqv_periph_bus_master.sv
// Single-beat initiator for the tinyQV peripheral bus (debug/DMA access to GPIO, UART, Borg).
// Latency with a no-wait responder: write 2 cycles, read 3 cycles from accept to rsp_valid; bad requests 1 cycle.
// Backpressure: req_ready only in IDLE; response is held stable until rsp_ready, strobes time out after TIMEOUT_CYCLES.
module tqv_periph_bus_master #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [10:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [10:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [1:0]  bus_write_n,
   output logic [1:0]  bus_read_n,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready,
   output logic        bus_read_complete
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, WRITE, READ, COMPLETE, RESP} state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic [1:0]      size;
   logic [1:0]      size_next;
   logic            accept;
   logic            illegal;
   logic            timeout;
   logic [31:0]     masked;
   logic            req_ready_next;
   logic            rsp_valid_next;
   logic            complete_next;
   logic [1:0]      write_n_next;
   logic [1:0]      read_n_next;

   assign accept    = (state == IDLE) && req_valid;
   assign illegal   = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
   // count holds the number of strobe cycles already completed, so the
   // current cycle is the last allowed one when it equals TIMEOUT_CYCLES-1
   assign timeout   = (count == CW'(TIMEOUT_CYCLES - 1));
   assign size_next = accept ? req_size : size;

   // Read data zero-extended to the access size
   always_comb begin
      masked = bus_rdata;
      case (size)
         2'd0:    masked = {24'h0, bus_rdata[7:0]};
         2'd1:    masked = {16'h0, bus_rdata[15:0]};
         default: masked = bus_rdata;
      endcase
   end

   // Next-state selection
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (illegal)        state_next = RESP;
               else if (req_write) state_next = WRITE;
               else                state_next = READ;
            end
         end
         WRITE: begin
            if (bus_ready || timeout) state_next = RESP;
         end
         READ: begin
            if (bus_ready)    state_next = COMPLETE;
            else if (timeout) state_next = RESP;
         end
         COMPLETE: state_next = RESP;
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output values decoded from the state being entered, so every output is a flop
   always_comb begin
      req_ready_next = (state_next == IDLE);
      rsp_valid_next = (state_next == RESP);
      complete_next  = (state_next == COMPLETE);
      write_n_next   = (state_next == WRITE) ? size_next : 2'b11;
      read_n_next    = (state_next == READ)  ? size_next : 2'b11;
   end

   // State and control-output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         req_ready         <= 1'b1;
         rsp_valid         <= 1'b0;
         bus_read_complete <= 1'b0;
         bus_write_n       <= 2'b11;
         bus_read_n        <= 2'b11;
      end else begin
         state             <= state_next;
         req_ready         <= req_ready_next;
         rsp_valid         <= rsp_valid_next;
         bus_read_complete <= complete_next;
         bus_write_n       <= write_n_next;
         bus_read_n        <= read_n_next;
      end
   end

   // Request latch, strobe-cycle counter and response data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_addr  <= 11'h0;
         bus_wdata <= 32'h0;
         size      <= 2'd0;
         count     <= '0;
         rsp_rdata <= 32'h0;
         rsp_error <= 1'b0;
      end else if (accept) begin
         bus_addr  <= req_addr;
         bus_wdata <= req_wdata;
         size      <= req_size;
         count     <= '0;
         rsp_rdata <= 32'h0;
         rsp_error <= illegal;
      end else if ((state == WRITE) || (state == READ)) begin
         count <= count + CW'(1);
         if (bus_ready) begin
            if (state == READ) rsp_rdata <= masked;
         end else if (timeout) begin
            rsp_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tqv_periph_bus_master.sv
// Bench for tqv_periph_bus_master: directed vector table, randomized transactions
// against a rule-level model, and a mid-access asynchronous reset sequence.
// A simple responder model answers strobes after a per-transaction delay.
module tb_tqv_periph_bus_master;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [1:0]  req_size;
   logic [10:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [31:0] rsp_rdata;
   logic [10:0] bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic [1:0]  bus_write_n, bus_read_n;
   logic        bus_ready, bus_read_complete;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tqv_periph_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_write_n(bus_write_n), .bus_read_n(bus_read_n), .bus_rdata(bus_rdata),
      .bus_ready(bus_ready), .bus_read_complete(bus_read_complete)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic [31:0] bdata;
      int          delay;      // strobe cycles before bus_ready; -1 = never
      int          hold;       // cycles rsp_ready stays low once rsp_valid is seen
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_slen;   // strobe length in cycles
      int          exp_cmpl;   // read_complete pulses
      int          exp_lat;    // accept cycle to first rsp_valid cycle
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          slen;
      int          cmpl;
      int          lat;
      int          bad;
      int          hung;
      int          wt;
   } obs_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected outcome derived directly from the access rules
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      logic bad_req;
      logic [31:0] mask;
      bad_req = (v.size == 2'd3) || (v.size == 2'd1 && v.addr[0]) ||
                (v.size == 2'd2 && v.addr[1:0] != 2'b00);
      mask = (v.size == 2'd0) ? 32'h0000_00FF : (v.size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      r.exp_cmpl  = 0;
      r.exp_rdata = 32'h0;
      if (bad_req) begin
         r.exp_err = 1'b1; r.exp_slen = 0; r.exp_lat = 1;
      end else if (v.delay < 0 || v.delay >= TO) begin
         r.exp_err = 1'b1; r.exp_slen = TO; r.exp_lat = TO + 1;
      end else begin
         r.exp_err  = 1'b0;
         r.exp_slen = v.delay + 1;
         if (v.wr) begin
            r.exp_lat = v.delay + 2;
         end else begin
            r.exp_lat   = v.delay + 3;
            r.exp_cmpl  = 1;
            r.exp_rdata = v.bdata & mask;
         end
      end
      return r;
   endfunction

   task automatic run_txn(input vec_t v, output obs_t o);
      int   k;
      int   guard;
      bit   done;
      logic [1:0] sv, other;
      o.err = 1'b0; o.rdata = 32'h0; o.slen = 0; o.cmpl = 0;
      o.lat = 0; o.bad = 0; o.hung = 0; o.wt = 0;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_write = v.wr;
      req_size  = v.size;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      o.wt = guard;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_size  = 2'($urandom);
      req_addr  = 11'($urandom);
      req_wdata = $urandom;
      k = 1;
      done = 1'b0;
      while (!done && k < 100) begin
         sv    = v.wr ? bus_write_n : bus_read_n;
         other = v.wr ? bus_read_n  : bus_write_n;
         if (sv != 2'b11) begin
            o.slen++;
            if (sv !== v.size || other !== 2'b11 || bus_addr !== v.addr ||
                (v.wr && bus_wdata !== v.wdata)) o.bad++;
         end else if (other !== 2'b11) begin
            o.bad++;
         end
         if (bus_read_complete) o.cmpl++;
         if (sv != 2'b11 && v.delay >= 0 && o.slen - 1 == v.delay) begin
            bus_ready = 1'b1;
            bus_rdata = v.bdata;
         end else begin
            bus_ready = 1'b0;
            bus_rdata = $urandom;
         end
         if (rsp_valid) begin
            o.lat   = k;
            o.err   = rsp_error;
            o.rdata = rsp_rdata;
            done    = 1'b1;
         end else begin
            @(negedge clk);
            k++;
         end
      end
      if (!done) begin
         o.hung = 1;
         return;
      end
      for (int h = 0; h < v.hold; h++) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_error !== o.err ||
             req_ready !== 1'b0 || bus_read_n !== 2'b11 || bus_write_n !== 2'b11) o.bad++;
         @(negedge clk);
      end
      if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata) o.bad++;
      rsp_ready = 1'b1;
      @(posedge clk);
   endtask

   task automatic compare(input string tag, input vec_t e, input obs_t o);
      check({tag, " hung"},       32'(o.hung),  32'd0);
      check({tag, " accept_wait"}, 32'(o.wt),   32'd0);
      check({tag, " strobe_len"}, 32'(o.slen),  32'(e.exp_slen));
      check({tag, " complete"},   32'(o.cmpl),  32'(e.exp_cmpl));
      check({tag, " latency"},    32'(o.lat),   32'(e.exp_lat));
      check({tag, " error"},      {31'h0, o.err}, {31'h0, e.exp_err});
      check({tag, " rdata"},      o.rdata,      e.exp_rdata);
      check({tag, " bus_bad"},    32'(o.bad),   32'd0);
   endtask

   initial begin
      vec_t v;
      obs_t o;

      //          wr    size   addr     wdata         bdata        dly hold err  rdata         slen cmpl lat
      tbl[0]  = '{1'b1, 2'd2, 11'h040, 32'h0000_00A5, 32'h0,        0, 0, 1'b0, 32'h0,         1,  0,  2};
      tbl[1]  = '{1'b0, 2'd0, 11'h044, 32'h0,         32'h1234_5678, 3, 0, 1'b0, 32'h0000_0078, 4,  1,  6};
      tbl[2]  = '{1'b0, 2'd2, 11'h5C0, 32'h0,         32'h0,        -1, 0, 1'b1, 32'h0,         8,  0,  9};
      tbl[3]  = '{1'b0, 2'd1, 11'h081, 32'h0,         32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0,         0,  0,  1};
      tbl[4]  = '{1'b0, 2'd3, 11'h000, 32'h0,         32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0,         0,  0,  1};
      tbl[5]  = '{1'b1, 2'd1, 11'h082, 32'hBEEF_1234, 32'h0,        2, 0, 1'b0, 32'h0,         3,  0,  4};
      tbl[6]  = '{1'b0, 2'd1, 11'h0FE, 32'h0,         32'hCAFE_BEEF, 7, 0, 1'b0, 32'h0000_BEEF, 8,  1, 10};
      tbl[7]  = '{1'b1, 2'd0, 11'h7FF, 32'h0000_0055, 32'h0,        8, 0, 1'b1, 32'h0,         8,  0,  9};
      tbl[8]  = '{1'b1, 2'd2, 11'h002, 32'h1111_1111, 32'h0,        0, 0, 1'b1, 32'h0,         0,  0,  1};
      tbl[9]  = '{1'b0, 2'd2, 11'h7FC, 32'h0,         32'hDEAD_BEEF, 0, 2, 1'b0, 32'hDEAD_BEEF, 1,  1,  3};
      tbl[10] = '{1'b0, 2'd2, 11'h010, 32'h0,         32'h1111_2222, 1, 5, 1'b0, 32'h1111_2222, 2,  1,  4};
      tbl[11] = '{1'b0, 2'd0, 11'h013, 32'h0,         32'hAABB_CCDD, 0, 5, 1'b0, 32'h0000_00DD, 1,  1,  3};

      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = 11'h0; req_wdata = 32'h0;
      rsp_ready = 1'b0; bus_rdata = 32'h0; bus_ready = 1'b0;
      #12;
      check("reset req_ready", {31'h0, req_ready}, 32'd1);
      check("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("reset rsp_error", {31'h0, rsp_error}, 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset write_n",   {30'h0, bus_write_n}, 32'd3);
      check("reset read_n",    {30'h0, bus_read_n},  32'd3);
      check("reset complete",  {31'h0, bus_read_complete}, 32'd0);
      check("reset bus_addr",  {21'h0, bus_addr}, 32'h0);
      check("reset bus_wdata", bus_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i], o);
         compare($sformatf("vec%0d", i), tbl[i], o);
      end

      for (int i = 0; i < 40; i++) begin
         v.wr    = 1'($urandom);
         v.size  = 2'($urandom);
         v.addr  = 11'($urandom);
         if ($urandom_range(3, 0) != 0) begin
            if (v.size == 2'd1) v.addr[0] = 1'b0;
            if (v.size == 2'd2) v.addr[1:0] = 2'b00;
         end
         v.wdata = $urandom;
         v.bdata = $urandom;
         v.delay = int'($urandom_range(10, 0)) - 1;
         v.hold  = int'($urandom_range(3, 0));
         v = model(v);
         run_txn(v, o);
         compare($sformatf("rnd%0d", i), v, o);
      end

      // Asynchronous reset in the middle of a read strobe
      @(negedge clk);
      rsp_ready = 1'b0; bus_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 11'h100;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midread strobe", {30'h0, bus_read_n}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst read_n",    {30'h0, bus_read_n}, 32'd3);
      check("rst rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("rst req_ready", {31'h0, req_ready}, 32'd1);
      check("rst complete",  {31'h0, bus_read_complete}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post-rst req_ready", {31'h0, req_ready}, 32'd1);
      check("post-rst rsp_valid", {31'h0, rsp_valid}, 32'd0);
      check("post-rst read_n",    {30'h0, bus_read_n}, 32'd3);
      run_txn(tbl[1], o);
      compare("post-rst", tbl[1], o);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
